// File: rtl/operand_sequencer.sv
// operand_sequencer: drives operands a/b/c of the downstream combinational unit
// from a small programmable table, holds each entry for hold+1 cycles and
// samples the unit's result on the last cycle of each step.
// Optional build macro OPSEQ_LOOP_EN: the sequence repeats until stop is seen.
module operand_sequencer #(
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int HW    = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [3:0]    wr_a,
  input  logic [3:0]    wr_b,
  input  logic [3:0]    wr_c,
  input  logic [HW-1:0] wr_hold,
  input  logic [AW-1:0] last_idx,
  input  logic          start,
`ifdef OPSEQ_LOOP_EN
  input  logic          stop,
`endif
  input  logic [3:0]    y_in,
  output logic [3:0]    a,
  output logic [3:0]    b,
  output logic [3:0]    c,
  output logic [AW-1:0] step,
  output logic          busy,
  output logic          done,
  output logic [3:0]    res,
  output logic          res_valid,
  output logic [AW-1:0] res_step
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  typedef struct packed {
    logic [3:0]    a;
    logic [3:0]    b;
    logic [3:0]    c;
    logic [HW-1:0] hold;
  } entry_t;

  entry_t          tbl_q [DEPTH];
  state_e          state_q, state_d;
  logic [AW-1:0]   step_q, step_d;
  logic [AW-1:0]   last_q, last_d;
  logic [HW-1:0]   cnt_q, cnt_d;
  logic [3:0]      a_q, a_d, b_q, b_d, c_q, c_d;
  logic [3:0]      res_q, res_d;
  logic [AW-1:0]   res_step_q, res_step_d;
  logic            res_valid_q, res_valid_d;
  logic            stop_seen;
  logic [AW-1:0]   load_idx;
  logic            load_en;
`ifdef OPSEQ_LOOP_EN
  logic            stop_q, stop_d;
`endif

  // Table write port; writes are only accepted outside RUN.
  // NOTE: the table is deliberately left out of reset so it maps onto plain
  // storage; its contents are undefined until software writes them.
  always_ff @(posedge clk) begin
    if (wr_en && state_q != RUN) begin
      tbl_q[wr_addr] <= '{a: wr_a, b: wr_b, c: wr_c, hold: wr_hold};
    end
  end

  // State and output registers with synchronous reset.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      step_q      <= '0;
      last_q      <= '0;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      res_q       <= '0;
      res_step_q  <= '0;
      res_valid_q <= 1'b0;
`ifdef OPSEQ_LOOP_EN
      stop_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
      res_q       <= res_d;
      res_step_q  <= res_step_d;
      res_valid_q <= res_valid_d;
`ifdef OPSEQ_LOOP_EN
      stop_q      <= stop_d;
`endif
    end
  end

`ifdef OPSEQ_LOOP_EN
  assign stop_seen = stop_q | stop;
`else
  assign stop_seen = 1'b1;
`endif

  // Next-state logic: step sequencing, hold countdown and result capture.
  // NOTE: every signal assigned here gets a default first, otherwise paths
  // that skip an assignment would infer latches.
  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    c_d         = c_q;
    res_d       = res_q;
    res_step_d  = res_step_q;
    res_valid_d = 1'b0;
    load_en     = 1'b0;
    load_idx    = '0;
`ifdef OPSEQ_LOOP_EN
    stop_d      = stop_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          last_d  = last_idx;
          load_en = 1'b1;
          state_d = RUN;
`ifdef OPSEQ_LOOP_EN
          stop_d  = 1'b0;
`endif
        end
      end
      RUN: begin
`ifdef OPSEQ_LOOP_EN
        stop_d = stop_q | stop;
`endif
        if (cnt_q != '0) begin
          cnt_d = cnt_q - HW'(1);
        end else begin
          res_valid_d = 1'b1;
          res_d       = y_in;
          res_step_d  = step_q;
          if (step_q != last_q) begin
            load_en  = 1'b1;
            load_idx = step_q + AW'(1);
          end else if (stop_seen) begin
            state_d = DONE;
          end else begin
            load_en = 1'b1;   // wrap back to entry 0, stay in RUN
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (load_en) begin
      step_d = load_idx;
      cnt_d  = tbl_q[load_idx].hold;
      a_d    = tbl_q[load_idx].a;
      b_d    = tbl_q[load_idx].b;
      c_d    = tbl_q[load_idx].c;
    end
  end

  assign a         = a_q;
  assign b         = b_q;
  assign c         = c_q;
  assign step      = step_q;
  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign res       = res_q;
  assign res_valid = res_valid_q;
  assign res_step  = res_step_q;

endmodule
